// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU data-memory request port.
// One read or write is accepted per cycle. Read data is captured at the
// accepting edge and travels through a LATENCY-deep pipeline. It appears on
// rsp_* exactly LATENCY cycles later, and responses keep issue order.
// Build option: define MEM_BURST_EN to enable burst reads of BURST_LEN
// consecutive words. During a burst, req_ready is held low while the burst
// FSM issues one internal read per cycle.
module mem_responder #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 16,
  parameter int MEM_LOG2  = 13,
  parameter int LATENCY   = 4,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic [AWIDTH-1:0] rsp_addr,
  output logic              busy
);

  // Handshake: a request is taken on a rising edge where req_valid & req_ready.
  // There is no response backpressure, so the requester must sink every
  // rsp_valid cycle.

  localparam int DEPTH = 1 << MEM_LOG2;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              accept;
  logic              wr_en;
  logic              issue_valid;
  logic              burst_active;
  logic [AWIDTH-1:0] req_addr_even;
  logic [AWIDTH-1:0] issue_addr;
  logic [DWIDTH-1:0] rd_word;

  logic [LATENCY-1:0] pipe_valid;
  logic [AWIDTH-1:0]  pipe_addr [LATENCY];
  logic [DWIDTH-1:0]  pipe_data [LATENCY];

  logic unused_bits;

  assign accept        = req_valid & req_ready;
  assign wr_en         = accept & req_wr;
  assign req_addr_even = {req_addr[AWIDTH-1:1], 1'b0};

`ifdef MEM_BURST_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     burst_cnt;
  logic [AWIDTH-1:0] burst_addr;
  logic              burst_start;
  logic              burst_last;

  // A burst read issues word 0 itself, so the FSM only covers words 1..N-1.
  assign burst_start = accept & ~req_wr & req_burst & (BURST_LEN > 1);
  assign burst_last  = (burst_cnt == CW'(BURST_LEN - 1));

  // Burst FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Burst FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (burst_start) state_next = ST_BURST;
      ST_BURST: if (burst_last)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Burst FSM outputs: block new requests while the burst owns the pipeline
  always_comb begin
    req_ready    = (state == ST_IDLE);
    burst_active = (state == ST_BURST);
  end

  // Burst word counter and next address, wrapping modulo 2^AWIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt  <= '0;
      burst_addr <= '0;
    end else if (burst_start) begin
      burst_cnt  <= CW'(1);
      burst_addr <= req_addr_even + AWIDTH'(2);
    end else if (burst_active) begin
      burst_cnt  <= burst_cnt + CW'(1);
      burst_addr <= burst_addr + AWIDTH'(2);
    end
  end

  assign issue_valid = (accept & ~req_wr) | burst_active;
  assign issue_addr  = burst_active ? burst_addr : req_addr_even;
  assign unused_bits = req_addr[0];
`else
  assign req_ready    = 1'b1;
  assign burst_active = 1'b0;
  assign issue_valid  = accept & ~req_wr;
  assign issue_addr   = req_addr_even;
  assign unused_bits  = ^{req_addr[0], req_burst};
`endif

  // Read the array before this edge's write lands, so a read sees the old word
  assign rd_word = mem[issue_addr[MEM_LOG2:1]];

  // Array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[req_addr[MEM_LOG2:1]] <= req_wdata;
  end

  // Read pipeline. A stage only reloads when a valid word enters it, so the
  // last stage, which drives rsp_*, holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_addr[i] <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= issue_valid;
      if (issue_valid) begin
        pipe_addr[0] <= issue_addr;
        pipe_data[0] <= rd_word;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_addr[i] <= pipe_addr[i-1];
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign rsp_valid = pipe_valid[LATENCY-1];
  assign rsp_data  = pipe_data[LATENCY-1];
  assign rsp_addr  = pipe_addr[LATENCY-1];
  assign busy      = (|pipe_valid) | burst_active;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a
// word-array reference model. The expected queue holds {due cycle, addr, data}
// for each read response.
module tb_mem_responder;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int ML   = 13;
  localparam int LAT  = 4;
  localparam int BLEN = 8;
`ifdef MEM_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic          req_burst;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          busy;

  mem_responder #(
    .DWIDTH(DW), .AWIDTH(AW), .MEM_LOG2(ML), .LATENCY(LAT), .BURST_LEN(BLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] model_mem [1 << ML];
  logic [63:0]   exp_q [$];
  int            cyc;
  int            burst_end;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  int            n_cmp;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Compare all outputs with the model for the current cycle
  task automatic check_outputs();
    logic ev;
    ev = (exp_q.size() > 0) && (exp_q[0][63:32] == 32'(cyc));
    if (ev) begin
      last_addr = exp_q[0][31:16];
      last_data = exp_q[0][15:0];
    end
    chk("busy", 32'(busy), 32'((exp_q.size() > 0) || (cyc < burst_end)));
    chk("req_ready", 32'(req_ready), 32'(cyc >= burst_end));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_data", 32'(rsp_data), 32'(last_data));
    chk("rsp_addr", 32'(rsp_addr), 32'(last_addr));
    if (ev) void'(exp_q.pop_front());
  endtask

  // Driver: present one request for one clock, update the model, then check
  task automatic step(input logic v, input logic w, input logic b,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic          rdy;
    logic [AW-1:0] ad;
    rdy       = (cyc >= burst_end);
    req_valid = v;
    req_wr    = w;
    req_burst = b;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    cyc++;
    if (v && rdy) begin
      if (w) begin
        model_mem[a[ML:1]] = d;
      end else if (b && BURST_ON) begin
        for (int i = 0; i < BLEN; i++) begin
          ad = {a[AW-1:1], 1'b0} + AW'(2 * i);
          exp_q.push_back({32'(cyc + LAT - 1 + i), ad, model_mem[ad[ML:1]]});
        end
        burst_end = cyc + BLEN - 1;
      end else begin
        ad = {a[AW-1:1], 1'b0};
        exp_q.push_back({32'(cyc + LAT - 1), ad, model_mem[ad[ML:1]]});
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [12:0] word;
    n_cmp = 0; n_err = 0; cyc = 0; burst_end = 0;
    last_addr = '0; last_data = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Preload the words used by later reads
    for (int i = 0; i < 72; i++) step(1'b1, 1'b1, 1'b0, AW'(2 * i), DW'($urandom));

    // Write then read the next cycle
    step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    step(1'b1, 1'b0, 1'b0, 16'h0010, '0);
    idle(LAT);
    // Odd address read: bit 0 ignored
    step(1'b1, 1'b1, 1'b0, 16'h0020, 16'h5A5A);
    step(1'b1, 1'b0, 1'b0, 16'h0021, '0);
    idle(LAT);
    // Three back-to-back reads
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h000A);
    step(1'b1, 1'b1, 1'b0, 16'h0002, 16'h000B);
    step(1'b1, 1'b1, 1'b0, 16'h0004, 16'h000C);
    step(1'b1, 1'b0, 1'b0, 16'h0000, '0);
    step(1'b1, 1'b0, 1'b0, 16'h0002, '0);
    step(1'b1, 1'b0, 1'b0, 16'h0004, '0);
    idle(LAT + 1);
    // Read, then overwrite the same word, then read again
    step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h1111);
    step(1'b1, 1'b0, 1'b0, 16'h0040, '0);
    step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h2222);
    step(1'b1, 1'b0, 1'b0, 16'h0040, '0);
    idle(LAT + 1);

    // Randomized mix, with aliased upper address bits and random bit 0
    for (int i = 0; i < 400; i++) begin
      word = 13'($urandom_range(0, 63));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0),
           {2'($urandom_range(0, 3)), word, 1'($urandom_range(0, 1))},
           DW'($urandom));
    end
    idle(LAT + BLEN);

`ifdef MEM_BURST_EN
    // Burst wrapping past the top of the address space; requests during the
    // burst must be refused
    step(1'b1, 1'b1, 1'b0, 16'hFFFC, DW'($urandom));
    step(1'b1, 1'b1, 1'b0, 16'hFFFE, DW'($urandom));
    step(1'b1, 1'b0, 1'b1, 16'hFFFC, '0);
    for (int i = 0; i < BLEN - 1; i++) step(1'b1, 1'b1, 1'b0, 16'h0002, 16'hDEAD);
    idle(LAT + 2);
    // A write with req_burst set is a plain write
    step(1'b1, 1'b1, 1'b1, 16'h0006, 16'h7777);
    step(1'b1, 1'b0, 1'b0, 16'h0006, '0);
    idle(LAT + 1);
`endif

    // Reset with two reads in flight
    step(1'b1, 1'b0, 1'b0, 16'h0002, '0);
    step(1'b1, 1'b0, 1'b0, 16'h0004, '0);
    idle(1);
    rst_n = 1'b0;
    exp_q.delete();
    burst_end = 0;
    last_addr = '0;
    last_data = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle(10);
    step(1'b1, 1'b0, 1'b0, 16'h0010, '0);
    idle(LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU data-memory request interface: accepts one read or write per cycle and returns read data a fixed LATENCY cycles later.
- Replaces the single-cycle data memory when the pipelined CPU and cache-fill logic need realistic multi-cycle memory.
- Reads are pipelined, so up to LATENCY reads can be in flight at once.
- Optional burst reads stream consecutive words, for cache block fills.

Parameters:
DWIDTH, 16, data word width in bits
AWIDTH, 16, byte-address width
MEM_LOG2, 13, log2 of array depth in words (8K words)
LATENCY, 4, request-to-response cycles for reads (legal range 1..8)
BURST_LEN, 8, words per burst read (power of two; used only with MEM_BURST_EN)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present this cycle
req_ready  output  1  responder can accept a request this cycle
req_wr  input  1  1 = write, 0 = read
req_burst  input  1  1 = burst read (ignored without MEM_BURST_EN)
req_addr  input  AWIDTH  byte address; bit 0 ignored
req_wdata  input  DWIDTH  write data
rsp_valid  output  1  read data valid, one-cycle pulse per word
rsp_data  output  DWIDTH  read data
rsp_addr  output  AWIDTH  even byte address of the word in rsp_data
busy  output  1  any read in flight or burst active

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0, req_ready=1.
  - All pipeline valid bits cleared; burst FSM to IDLE.
  - Memory array is not cleared.
- Acceptance and addressing:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - Word index = req_addr[MEM_LOG2:1]; upper bits alias.
- Write:
  - Array updated at the accepting edge.
  - No response is generated.
  - A read accepted on any later edge sees the new value.
- Read:
  - Array is read at the accepting edge, cycle T. The value captured is the one written before T.
  - The word enters a LATENCY-deep shift pipeline; each stage holds valid, addr and data.
  - rsp_valid=1 during cycle T+LATENCY with rsp_data and rsp_addr = {req_addr[AWIDTH-1:1],1'b0}.
  - Back-to-back reads yield back-to-back responses in issue order.
- No response backpressure: the requester must sink every rsp_valid cycle.
- Writes and reads may interleave freely. A write never corrupts an in-flight read's captured data.
- Idle outputs: when rsp_valid=0, rsp_data and rsp_addr hold their last values.
- busy = OR of pipeline valid bits, OR burst FSM != IDLE.
- Reset mid-operation: in-flight reads are dropped. No rsp_valid appears after reset release until a new read is accepted.

Optional Feature:
Macro MEM_BURST_EN.
- Defined:
  - FSM states are IDLE and BURST.
  - In IDLE, an accepted read with req_burst=1 issues word 0 at the accepting edge and moves to BURST with count=1.
  - In BURST:
    - req_ready=0.
    - One internal read is issued per cycle into the same pipeline.
    - Each issued address = previous + 2, wrapping modulo 2^AWIDTH.
    - Return to IDLE after word BURST_LEN-1 is issued.
  - Responses arrive on BURST_LEN consecutive cycles, starting at T+LATENCY.
  - A write with req_burst=1 is a plain single write.
  - Reset in BURST returns the FSM to IDLE immediately.
- Undefined:
  - req_burst is ignored and there is no FSM.
  - req_ready is tied to 1.

Test Plan:
- Write 0x1234 to address 0x0010, then read 0x0010 the next cycle -> rsp_valid at read cycle +4, rsp_data=0x1234, rsp_addr=0x0010.
- Read 0x0021 -> rsp_addr=0x0020, data equals the word written at 0x0020.
- Reads to 0x0000, 0x0002, 0x0004 on three consecutive cycles (contents 0xA, 0xB, 0xC) -> rsp_valid high three consecutive cycles, data 0xA, 0xB, 0xC in that order.
- Read 0x0040 (old 0x1111), then write 0x2222 to 0x0040 the next cycle -> response is 0x1111. A read one cycle later -> 0x2222.
- Issue 2 reads, assert rst_n=0 for one cycle two cycles after issue -> no rsp_valid for 10 cycles after release; busy=0.
- MEM_BURST_EN, burst read at 0xFFFC (BURST_LEN=8) -> req_ready low 7 cycles; 8 responses at addresses 0xFFFC, 0xFFFE, 0x0000 … 0x000A on consecutive cycles starting T+4.
